mcore: RTL

MCORE -- requirements
Module: mcore

---
 rtl/mcore.sv | 363 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcore.sv
// mcore -- multicycle MIPS-subset core with internal instruction and data
// memories. The pc and data addresses are word addresses.
//
// Parameters:
//   IMEM_DEPTH  instruction words in imem (default 256)
//   DMEM_DEPTH  data words in dmem (default 4096)
//   NREG        integer registers, power of 2 in 8..32. Register fields use
//               their low log2(NREG) bits.
//
// Ports:
//   CLK, RST                      clock; asynchronous active-high reset
//   start                         run request (IDLE->FETCH, HALT->IDLE)
//   prog_we/prog_addr/prog_data   imem write port, honoured only in IDLE
//   in_valid/in_data/in_ready     IN channel (ready/valid)
//   out_valid/out_data/out_ready  OUT channel (ready/valid)
//   busy                          high in FETCH/EXEC/MEM/IO
//   halted                        high in HALT
//   err                           sticky fault flag, cleared on HALT->IDLE
//   pc_out                        current pc register
//
// Build option: defining MCORE_IO_EN enables the IN/OUT handshakes.
// Without it, IN writes 0 to rt, OUT is a NOP, and both take 2 cycles.
module mcore #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 4096,
  parameter int unsigned NREG       = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [31:0] pc_out
);

  localparam int unsigned RW  = $clog2(NREG);
  localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [31:0] IMEM_LIM = 32'(IMEM_DEPTH);
  localparam logic [31:0] DMEM_LIM = 32'(DMEM_DEPTH);
  // Link register: the low RW bits of 31 are all ones for any legal NREG.
  localparam logic [RW-1:0] RA = '1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_IN    = 6'h1A;
  localparam logic [5:0] OP_OUT   = 6'h1B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_IO,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_addr;
  logic        r_err;
  logic [31:0] r_regs [NREG];
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_dmem [DMEM_DEPTH];

  // Instruction fields
  logic [5:0]    w_op;
  logic [5:0]    w_funct;
  logic [RW-1:0] w_rs;
  logic [RW-1:0] w_rt;
  logic [RW-1:0] w_rd;
  logic [4:0]    w_shamt;
  logic [31:0]   w_simm;
  logic [31:0]   w_zimm;
  logic [31:0]   w_rs_val;
  logic [31:0]   w_rt_val;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_br_tgt;
  logic [31:0]   w_j_tgt;
  logic          w_addr_ok;

  // Next-state / write controls
  logic [31:0]   w_pc_next;
  logic          w_rf_we;
  logic [RW-1:0] w_rf_waddr;
  logic [31:0]   w_rf_wdata;
  logic          w_err_set;
  logic          w_err_clr;
  logic          w_addr_ld;
  logic          w_imem_we;
  logic          w_dmem_we;

`ifdef MCORE_IO_EN
  logic          r_io_out;
  logic [7:0]    r_out_data;
  logic          w_io_ld;
  logic          w_io_is_out;
`endif

  assign w_op     = r_inst[31:26];
  assign w_funct  = r_inst[5:0];
  assign w_rs     = r_inst[21 +: RW];
  assign w_rt     = r_inst[16 +: RW];
  assign w_rd     = r_inst[11 +: RW];
  assign w_shamt  = r_inst[10:6];
  assign w_simm   = {{16{r_inst[15]}}, r_inst[15:0]};
  assign w_zimm   = {16'h0000, r_inst[15:0]};
  // Register 0 is never written and resets to zero, so it always reads zero.
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];
  assign w_pc_inc = r_pc + 32'd1;
  assign w_br_tgt = w_pc_inc + w_simm;
  assign w_j_tgt  = {6'b000000, r_inst[25:0]};
  assign w_addr_ok = (r_addr < DMEM_LIM);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_rf_we      = 1'b0;
    w_rf_waddr   = w_rt;
    w_rf_wdata   = '0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    w_addr_ld    = 1'b0;
    w_imem_we    = 1'b0;
    w_dmem_we    = 1'b0;
`ifdef MCORE_IO_EN
    w_io_ld      = 1'b0;
    w_io_is_out  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (prog_we) begin
          if (prog_addr < IMEM_LIM) w_imem_we = 1'b1;
          else                      w_err_set = 1'b1;
        end
        if (start) begin
          w_state_next = S_FETCH;
          w_pc_next    = '0;
        end
      end

      S_FETCH: begin
        if (r_pc >= IMEM_LIM) begin
          w_err_set    = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_op)
          OP_RTYPE: begin
            w_rf_waddr = w_rd;
            case (w_funct)
              F_ADD: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val + w_rt_val; end
              F_SUB: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val - w_rt_val; end
              F_AND: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val & w_rt_val; end
              F_OR:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val | w_rt_val; end
              F_NOR: begin w_rf_we = 1'b1; w_rf_wdata = ~(w_rs_val | w_rt_val); end
              F_SLL: begin w_rf_we = 1'b1; w_rf_wdata = w_rt_val << w_shamt; end
              F_SRL: begin w_rf_we = 1'b1; w_rf_wdata = w_rt_val >> w_shamt; end
              F_SLT: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = {31'b0, ($signed(w_rs_val) < $signed(w_rt_val))};
              end
              F_JR:  w_pc_next = w_rs_val;
              F_JALR: begin
                w_pc_next  = w_rs_val;
                w_rf_we    = 1'b1;
                w_rf_waddr = (w_rd != '0) ? w_rd : RA;
                w_rf_wdata = w_pc_inc;
              end
              default: w_err_set = 1'b1;
            endcase
          end
          OP_ADDI: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val + w_simm; end
          OP_ANDI: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val & w_zimm; end
          OP_ORI:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val | w_zimm; end
          OP_SLTI: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = {31'b0, ($signed(w_rs_val) < $signed(w_simm))};
          end
          OP_LUI:  begin w_rf_we = 1'b1; w_rf_wdata = {r_inst[15:0], 16'h0000}; end
          OP_BEQ:  if (w_rs_val == w_rt_val) w_pc_next = w_br_tgt;
          OP_BNE:  if (w_rs_val != w_rt_val) w_pc_next = w_br_tgt;
          OP_J: begin
            // A jump to itself is the program's halt idiom.
            if (w_j_tgt == r_pc) begin
              w_state_next = S_HALT;
              w_pc_next    = r_pc;
            end else begin
              w_pc_next = w_j_tgt;
            end
          end
          OP_JAL: begin
            w_pc_next  = w_j_tgt;
            w_rf_we    = 1'b1;
            w_rf_waddr = RA;
            w_rf_wdata = w_pc_inc;
          end
          OP_LW, OP_SW: begin
            // pc advances when MEM completes.
            w_state_next = S_MEM;
            w_pc_next    = r_pc;
            w_addr_ld    = 1'b1;
          end
`ifdef MCORE_IO_EN
          OP_IN: begin
            w_state_next = S_IO;
            w_pc_next    = r_pc;
            w_io_ld      = 1'b1;
            w_io_is_out  = 1'b0;
          end
          OP_OUT: begin
            w_state_next = S_IO;
            w_pc_next    = r_pc;
            w_io_ld      = 1'b1;
            w_io_is_out  = 1'b1;
          end
`else
          OP_IN: begin w_rf_we = 1'b1; w_rf_wdata = '0; end
          OP_OUT: ;
`endif
          default: w_err_set = 1'b1;
        endcase
      end

      S_MEM: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        if (w_op == OP_LW) begin
          w_rf_we    = 1'b1;
          w_rf_wdata = w_addr_ok ? r_dmem[r_addr[DAW-1:0]] : '0;
        end else if (w_addr_ok) begin
          w_dmem_we = 1'b1;
        end
        if (!w_addr_ok) w_err_set = 1'b1;
      end

      S_IO: begin
`ifdef MCORE_IO_EN
        if (r_io_out) begin
          if (out_ready) begin
            w_state_next = S_FETCH;
            w_pc_next    = w_pc_inc;
          end
        end else if (in_valid) begin
          w_state_next = S_FETCH;
          w_pc_next    = w_pc_inc;
          w_rf_we      = 1'b1;
          w_rf_wdata   = {24'h000000, in_data};
        end
`else
        w_state_next = S_FETCH;
`endif
      end

      S_HALT: begin
        if (start) begin
          w_state_next = S_IDLE;
          w_err_clr    = 1'b1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc   <= '0;
      r_inst <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
`ifdef MCORE_IO_EN
      r_io_out   <= 1'b0;
      r_out_data <= '0;
`endif
    end else begin
      r_pc <= w_pc_next;
      if (r_state == S_FETCH) r_inst <= r_imem[r_pc[IAW-1:0]];
      if (w_addr_ld) r_addr <= w_rs_val + w_simm;
      if (w_err_clr)      r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_rf_we && (w_rf_waddr != '0)) r_regs[w_rf_waddr] <= w_rf_wdata;
`ifdef MCORE_IO_EN
      if (w_io_ld) begin
        r_io_out <= w_io_is_out;
        if (w_io_is_out) r_out_data <= w_rt_val[7:0];
      end
`endif
    end
  end

  // Memories are not reset. A reset forces IDLE asynchronously, which drops
  // w_dmem_we before the next edge, so an interrupted SW never lands.
  always_ff @(posedge CLK) begin
    if (w_imem_we) r_imem[prog_addr[IAW-1:0]] <= prog_data;
    if (w_dmem_we) r_dmem[r_addr[DAW-1:0]] <= w_rt_val;
  end

  assign busy   = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                  (r_state == S_MEM)   || (r_state == S_IO);
  assign halted = (r_state == S_HALT);
  assign err    = r_err;
  assign pc_out = r_pc;

`ifdef MCORE_IO_EN
  assign in_ready  = (r_state == S_IO) && !r_io_out;
  assign out_valid = (r_state == S_IO) && r_io_out;
  assign out_data  = r_out_data;
`else
  logic w_unused_io;
  assign w_unused_io = ^{in_valid, in_data, out_ready};
  assign in_ready  = 1'b0;
  assign out_valid = 1'b0;
  assign out_data  = '0;
`endif

endmodule
